// File: rtl/branch_redirect_ctrl_pkg.sv
// branch_redirect_ctrl_pkg: shared types and constants for the branch redirect controller
package branch_redirect_ctrl_pkg;
  typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_e;
  localparam int PC_W      = 32;
  localparam int CNT_W     = 32;
  localparam int BHT_IDX_W = 4;
  localparam int BHT_N     = 1 << BHT_IDX_W;
  localparam logic [1:0] BHT_RESET = 2'b01;
endpackage

// File: rtl/branch_redirect_ctrl_bht.sv
// branch_history_table: 2-bit saturating direction counters, one read port, one update port
module branch_history_table
  import branch_redirect_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BHT_IDX_W-1:0] rd_idx_i,
  output logic                 rd_taken_o,
  input  logic                 upd_en_i,
  input  logic [BHT_IDX_W-1:0] upd_idx_i,
  input  logic                 upd_taken_i
);
  logic [1:0] ctr_q [BHT_N];
  logic [1:0] ctr_old;
  logic [1:0] ctr_d;
  assign rd_taken_o = ctr_q[rd_idx_i][1];
  assign ctr_old    = ctr_q[upd_idx_i];
  // saturating step of the entry being updated
  always_comb begin
    ctr_d = upd_taken_i ? ((ctr_old == 2'b11) ? ctr_old : ctr_old + 2'b01)
                        : ((ctr_old == 2'b00) ? ctr_old : ctr_old - 2'b01);
  end
  // table storage, cleared to weakly not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) ctr_q[i] <= BHT_RESET;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_d;
    end
  end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: resolves EX branches/jumps, holds a fetch redirect and flushes until accepted; BRANCH_PREDICT_EN adds a direction predictor
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic            ex_branch_i,
  input  logic            ex_jump_i,
  input  logic            ex_taken_i,
  input  logic            ex_pred_taken_i,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic [PC_W-1:0] ex_target_i,
  input  logic            fetch_ready_i,
  input  logic [PC_W-1:0] id_pc_i,
  output logic            id_pred_taken_o,
  output logic            redirect_valid_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic            flush_if_id_o,
  output logic            flush_id_ex_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);
  state_e           state_q;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;
  logic             resolve, branch_ev, mispred;
  logic             unused_id_pc;
  assign unused_id_pc = ^id_pc_i;
  // EX inputs only matter while IDLE; in REDIRECT they are squashed bubbles
  always_comb begin
    resolve       = (state_q == IDLE) && ex_valid_i && (ex_branch_i || ex_jump_i);
    branch_ev     = resolve && ex_branch_i;
    mispred       = resolve && (ex_jump_i || (ex_taken_i != ex_pred_taken_i));
    redirect_pc_d = (ex_jump_i || ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;
  end
  // FSM, latched redirect target and event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (branch_ev) branch_cnt_q <= branch_cnt_q + 1'b1;
      if (mispred) begin
        state_q       <= REDIRECT;
        redirect_pc_q <= redirect_pc_d;
        mispred_cnt_q <= mispred_cnt_q + 1'b1;
      end else if (state_q == REDIRECT && fetch_ready_i) begin
        state_q <= IDLE;
      end
    end
  end
  assign redirect_valid_o = (state_q == REDIRECT);
  assign flush_if_id_o    = redirect_valid_o;
  assign flush_id_ex_o    = redirect_valid_o;
  assign redirect_pc_o    = redirect_pc_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispred_cnt_o    = mispred_cnt_q;
`ifdef BRANCH_PREDICT_EN
  branch_history_table u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (id_pc_i[5:2]),
    .rd_taken_o (id_pred_taken_o),
    .upd_en_i   (branch_ev && !ex_jump_i),
    .upd_idx_i  (ex_pc_i[5:2]),
    .upd_taken_i(ex_taken_i)
  );
`else
  assign id_pred_taken_o = 1'b0;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: scoreboard bench with directed and random EX resolve traffic
module tb_branch_redirect_ctrl;
  logic        clk, rst_n;
  logic        ex_valid, ex_branch, ex_jump, ex_taken, ex_pred_taken, fetch_ready;
  logic [31:0] ex_pc, ex_target, id_pc;
  logic        id_pred_taken, redirect_valid, flush_if_id, flush_id_ex;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
    logic        pred;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_busy;
  logic [31:0] m_pc, m_bc, m_mc;
  int          m_bht[16];

  branch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid), .ex_branch_i(ex_branch), .ex_jump_i(ex_jump),
    .ex_taken_i(ex_taken), .ex_pred_taken_i(ex_pred_taken),
    .ex_pc_i(ex_pc), .ex_target_i(ex_target), .fetch_ready_i(fetch_ready),
    .id_pc_i(id_pc), .id_pred_taken_o(id_pred_taken),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
    .branch_cnt_o(branch_cnt), .mispred_cnt_o(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_pc = '0; m_bc = '0; m_mc = '0;
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
  endtask

  // Applies one cycle of inputs and queues what the outputs must be after the next edge.
  task automatic drive(input bit v, input bit br, input bit j, input bit t, input bit p,
                       input logic [31:0] pc, input logic [31:0] tgt, input bit frdy,
                       input logic [31:0] ipc);
    exp_t e;
    bit res;
    @(negedge clk);
    ex_valid = v; ex_branch = br; ex_jump = j; ex_taken = t; ex_pred_taken = p;
    ex_pc = pc; ex_target = tgt; fetch_ready = frdy; id_pc = ipc;
    res = !m_busy && v && (br || j);
    if (m_busy) begin
      if (frdy) m_busy = 0;
    end else if (res) begin
      if (br) m_bc = m_bc + 1;
      if (br && !j) m_bht[pc[5:2]] = t ? ((m_bht[pc[5:2]] < 3) ? m_bht[pc[5:2]] + 1 : 3)
                                       : ((m_bht[pc[5:2]] > 0) ? m_bht[pc[5:2]] - 1 : 0);
      if (j || (t != p)) begin
        m_busy = 1;
        m_pc   = (j || t) ? tgt : pc + 32'd4;
        m_mc   = m_mc + 1;
      end
    end
    e.rv = m_busy; e.rpc = m_pc; e.bc = m_bc; e.mc = m_mc;
`ifdef BRANCH_PREDICT_EN
    e.pred = (m_bht[ipc[5:2]] >= 2);
`else
    e.pred = 1'b0;
`endif
    q.push_back(e);
  endtask

  task automatic idle(input bit frdy);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, frdy, 32'h0);
  endtask

  // monitor: compares outputs just after every edge that has a queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        chk("flush_if_id", 32'(flush_if_id), 32'(e.rv));
        chk("flush_id_ex", 32'(flush_id_ex), 32'(e.rv));
        if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
        chk("branch_cnt", branch_cnt, e.bc);
        chk("mispred_cnt", mispred_cnt, e.mc);
        chk("id_pred_taken", 32'(id_pred_taken), 32'(e.pred));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_taken = 0; ex_pred_taken = 0;
    ex_pc = '0; ex_target = '0; fetch_ready = 0; id_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset redirect_valid", 32'(redirect_valid), 32'd0);
    chk("reset redirect_pc", redirect_pc, 32'd0);
    chk("reset branch_cnt", branch_cnt, 32'd0);
    chk("reset mispred_cnt", mispred_cnt, 32'd0);
    chk("reset id_pred_taken", 32'(id_pred_taken), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // not-taken branch correctly predicted
    drive(1, 1, 0, 0, 0, 32'h100, 32'h180, 1, 32'h0);
    // taken branch mispredicted, accepted at once
    drive(1, 1, 0, 1, 0, 32'h104, 32'h200, 1, 32'h0);
    idle(1);
    idle(1);
    // JAL with fetch stalled for five cycles and a resolve injected in the wait
    drive(1, 0, 1, 0, 0, 32'h300, 32'h40, 0, 32'h0);
    idle(0);
    drive(1, 1, 0, 1, 0, 32'h308, 32'h999, 0, 32'h0);
    idle(0); idle(0); idle(0);
    // resolve in the acceptance cycle is ignored
    drive(1, 0, 1, 0, 0, 32'h500, 32'h600, 1, 32'h0);
    idle(1);
    // predicted-taken branch resolved not-taken at the top of the address space
    drive(1, 1, 0, 0, 1, 32'hFFFFFFFC, 32'h20, 1, 32'h0);
    idle(1);
    // predictor training at index 4, read back through an aliasing ID PC
    drive(1, 1, 0, 1, 1, 32'h10, 32'h80, 1, 32'h50);
    drive(1, 1, 0, 1, 1, 32'h10, 32'h80, 1, 32'h50);
    drive(1, 1, 0, 1, 1, 32'h10, 32'h80, 1, 32'h50);
    idle(1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int k;
      logic [31:0] pc, ipc;
      k   = $urandom_range(0, 3);
      pc  = (32'($urandom_range(0, 15)) << 2) | ($urandom_range(0, 1) ? 32'hFFFFFFC0 : 32'h0);
      ipc = 32'($urandom_range(0, 15)) << 2;
      drive($urandom_range(0, 3) != 0, k == 1 || k == 2, k == 3, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), pc, $urandom, $urandom_range(0, 2) != 0, ipc);
    end
    idle(1);
    idle(1);

    // asynchronous reset in the middle of a stalled redirect
    drive(1, 0, 1, 0, 0, 32'h700, 32'h7F0, 0, 32'h0);
    @(posedge clk);
    #3;
    chk("pre-reset redirect_valid", 32'(redirect_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset redirect_valid", 32'(redirect_valid), 32'd0);
    chk("async reset flush_if_id", 32'(flush_if_id), 32'd0);
    chk("async reset flush_id_ex", 32'(flush_id_ex), 32'd0);
    chk("async reset redirect_pc", redirect_pc, 32'd0);
    chk("async reset branch_cnt", branch_cnt, 32'd0);
    chk("async reset mispred_cnt", mispred_cnt, 32'd0);
    ex_valid = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 1, 0, 32'h10, 32'h44, 1, 32'h10);
    idle(1);
    idle(1);
    @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
